// File: rtl/semaforo_if.sv
// Lamp/command bundle for the traffic-light controller: the controller (slave)
// reads START/VEL and drives the three registered lamp lines.
interface semaforo_if;
    logic START;
    logic VEL;
    logic LUZ_ROJA;
    logic LUZ_VERDE;
    logic LUZ_AMARILLA;

    modport master (
        output START,
        output VEL,
        input  LUZ_ROJA,
        input  LUZ_VERDE,
        input  LUZ_AMARILLA
    );

    modport slave (
        input  START,
        input  VEL,
        output LUZ_ROJA,
        output LUZ_VERDE,
        output LUZ_AMARILLA
    );
endinterface

// File: rtl/semaforo_ctrl.sv
// Traffic-light controller: VERDE -> AMARILLA -> ROJA while START is held, IDLE otherwise.
// Optional macro BLINK_IDLE_EN turns the IDLE display into a flashing yellow.
module semaforo_ctrl #(
    parameter int unsigned T_VERDE    = 8,
    parameter int unsigned T_AMARILLA = 3,
    parameter int unsigned T_ROJA     = 6,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned BLINK_T    = 4
) (
    input logic        CLK,
    input logic        RESET,
    semaforo_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VERDE    = 2'd1,
        AMARILLA = 2'd2,
        ROJA     = 2'd3
    } state_t;

    // Parameter sanity: every duration and the blink period must fit the counter.
    if (T_VERDE < 1 || T_AMARILLA < 1 || T_ROJA < 1 || BLINK_T < 1) begin : g_bad_dur
        $error("semaforo_ctrl: durations and BLINK_T must be >= 1");
    end
    if (T_VERDE > (1 << CNT_W) || T_AMARILLA > (1 << CNT_W) || T_ROJA > (1 << CNT_W)
        || BLINK_T > (1 << CNT_W)) begin : g_bad_w
        $error("semaforo_ctrl: CNT_W too narrow for the configured durations");
    end

    // Phase length minus one, halved (floor, min 1) in fast mode.
    function automatic logic [CNT_W-1:0] dur_m1(input int unsigned t, input logic fast);
        int unsigned d;
        if (fast) begin
            d = t >> 1;
            if (d == 0) begin
                d = 1;
            end else begin
                d = d;
            end
        end else begin
            d = t;
        end
        return CNT_W'(d - 1);
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             luz_roja_r, luz_verde_r, luz_amarilla_r;
    logic             luz_roja_s, luz_verde_s, luz_amarilla_s;

`ifdef BLINK_IDLE_EN
    logic             blink_on_r, blink_on_s;
    logic             blink_a_r, blink_a_s;
    logic [CNT_W-1:0] blink_cnt_r, blink_cnt_s;
    localparam logic [CNT_W-1:0] BLINK_M1 = CNT_W'(BLINK_T - 1);
`endif

    // Next-state and phase counter; VEL is only looked at when a phase is loaded.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.START) begin
                    state_s = VERDE;
                    cnt_s   = dur_m1(T_VERDE, bus.VEL);
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            VERDE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = AMARILLA;
                    cnt_s   = dur_m1(T_AMARILLA, bus.VEL);
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            AMARILLA: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ROJA;
                    cnt_s   = dur_m1(T_ROJA, bus.VEL);
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            ROJA: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    if (bus.START) begin
                        state_s = VERDE;
                        cnt_s   = dur_m1(T_VERDE, bus.VEL);
                    end else begin
                        state_s = IDLE;
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

`ifdef BLINK_IDLE_EN
    // Idle flasher: the first IDLE edge lights yellow, then it toggles every BLINK_T edges.
    always_comb begin
        blink_on_s  = 1'b0;
        blink_a_s   = 1'b0;
        blink_cnt_s = {CNT_W{1'b0}};
        if (state_s == IDLE) begin
            blink_on_s = 1'b1;
            if (!blink_on_r) begin
                blink_a_s   = 1'b1;
                blink_cnt_s = BLINK_M1;
            end else if (blink_cnt_r == {CNT_W{1'b0}}) begin
                blink_a_s   = ~blink_a_r;
                blink_cnt_s = BLINK_M1;
            end else begin
                blink_a_s   = blink_a_r;
                blink_cnt_s = blink_cnt_r - CNT_W'(1);
            end
        end else begin
            blink_on_s = 1'b0;
        end
    end
`endif

    // Lamp decode from the state being entered, so lamps change on the entry edge.
    always_comb begin
        luz_roja_s     = 1'b0;
        luz_verde_s    = 1'b0;
        luz_amarilla_s = 1'b0;
        case (state_s)
            IDLE: begin
`ifdef BLINK_IDLE_EN
                luz_amarilla_s = blink_a_s;
`else
                luz_roja_s     = 1'b1;
`endif
            end
            VERDE:    luz_verde_s    = 1'b1;
            AMARILLA: luz_amarilla_s = 1'b1;
            ROJA:     luz_roja_s     = 1'b1;
            default:  luz_roja_s     = 1'b1;
        endcase
    end

    // State, counter and lamp registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r        <= IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            luz_roja_r     <= 1'b1;
            luz_verde_r    <= 1'b0;
            luz_amarilla_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            luz_roja_r     <= luz_roja_s;
            luz_verde_r    <= luz_verde_s;
            luz_amarilla_r <= luz_amarilla_s;
        end
    end

`ifdef BLINK_IDLE_EN
    // Flasher registers; cleared by reset and whenever IDLE is left.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            blink_on_r  <= 1'b0;
            blink_a_r   <= 1'b0;
            blink_cnt_r <= {CNT_W{1'b0}};
        end else begin
            blink_on_r  <= blink_on_s;
            blink_a_r   <= blink_a_s;
            blink_cnt_r <= blink_cnt_s;
        end
    end
`endif

    assign bus.LUZ_ROJA     = luz_roja_r;
    assign bus.LUZ_VERDE    = luz_verde_r;
    assign bus.LUZ_AMARILLA = luz_amarilla_r;

endmodule
